// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI command/RAM controller.
package spi_pkg;

    localparam int unsigned ADDR_SIZE_DEF = 8;

    typedef enum logic [1:0] {
        WR_ADDR = 2'b00,
        WR_DATA = 2'b01,
        RD_ADDR = 2'b10,
        RD_DATA = 2'b11
    } cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DECODE,
        ST_RD_WAIT,
        ST_TX
    } ctrl_state_t;

endpackage

// File: rtl/spi_sp_ram.sv
// Single-port synchronous RAM with registered read data, no array reset.
module spi_sp_ram #(
    parameter int unsigned ADDR_SIZE = 8,
    parameter int unsigned MEM_DEPTH = 256
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_SIZE-1:0] addr,
    input  logic [ADDR_SIZE-1:0] din,
    output logic [ADDR_SIZE-1:0] dout
);

    logic [ADDR_SIZE-1:0] mem [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= din;
        end
        dout <= mem[addr];
    end

endmodule

// File: rtl/spi_ram_ctrl.sv
// Decodes SPI slave command words, sequences the RAM and returns read data
// to the slave through a tx_valid window of ADDR_SIZE cycles.
module spi_ram_ctrl
    import spi_pkg::*;
#(
    parameter int unsigned ADDR_SIZE = ADDR_SIZE_DEF,
    parameter int unsigned MEM_DEPTH = 2 ** ADDR_SIZE
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ADDR_SIZE+1:0] rx_data,
    input  logic                 rx_valid,
    output logic [ADDR_SIZE-1:0] tx_data,
    output logic                 tx_valid,
    output logic                 busy,
    output logic                 seq_err,
    output logic                 drop
);

    localparam int unsigned CNT_W = $clog2(ADDR_SIZE + 1);

    ctrl_state_t          state, state_nxt;
    cmd_t                 cmd_q;
    logic [ADDR_SIZE-1:0] payload_q;
    logic [ADDR_SIZE-1:0] wr_addr, rd_addr;
    logic                 wr_ok, rd_ok;
    logic [CNT_W-1:0]     tx_cnt;

    cmd_t                 rx_cmd;
    logic                 latch;
    logic                 seq_err_nxt;
    logic                 drop_nxt;
    logic                 ram_we;
    logic [ADDR_SIZE-1:0] ram_addr;
    logic [ADDR_SIZE-1:0] ram_q;

    assign rx_cmd = cmd_t'(rx_data[ADDR_SIZE+1:ADDR_SIZE]);

    function automatic logic [ADDR_SIZE-1:0] next_addr(input logic [ADDR_SIZE-1:0] a);
        return (a == ADDR_SIZE'(MEM_DEPTH - 1)) ? '0 : a + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, RAM strobes and pulse sources
    always_comb begin
        state_nxt   = state;
        latch       = 1'b0;
        seq_err_nxt = 1'b0;
        drop_nxt    = 1'b0;
        ram_we      = 1'b0;
        ram_addr    = rd_addr;
        unique case (state)
            ST_IDLE: begin
                if (rx_valid) begin
                    latch       = 1'b1;
                    state_nxt   = ST_DECODE;
                    seq_err_nxt = (rx_cmd == WR_DATA && !wr_ok) ||
                                  (rx_cmd == RD_DATA && !rd_ok);
                end
            end
            ST_DECODE: begin
                state_nxt = ST_IDLE;
                if (cmd_q == WR_DATA && wr_ok) begin
                    ram_we   = 1'b1;
                    ram_addr = wr_addr;
                end
                if (cmd_q == RD_DATA && rd_ok) begin
                    state_nxt = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: state_nxt = ST_TX;
            ST_TX: begin
                if (tx_cnt == '0) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (rx_valid && state != ST_IDLE) begin
            drop_nxt = 1'b1;
        end
    end

    // Registered outputs, command latch, address registers and TX counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy      <= 1'b0;
            seq_err   <= 1'b0;
            drop      <= 1'b0;
            tx_valid  <= 1'b0;
            tx_data   <= '0;
            cmd_q     <= WR_ADDR;
            payload_q <= '0;
            wr_addr   <= '0;
            rd_addr   <= '0;
            wr_ok     <= 1'b0;
            rd_ok     <= 1'b0;
            tx_cnt    <= '0;
        end else begin
            busy     <= (state_nxt != ST_IDLE);
            seq_err  <= seq_err_nxt;
            drop     <= drop_nxt;
            tx_valid <= (state_nxt == ST_TX);
            if (latch) begin
                cmd_q     <= rx_cmd;
                payload_q <= rx_data[ADDR_SIZE-1:0];
            end
            if (state == ST_DECODE) begin
                unique case (cmd_q)
                    WR_ADDR: begin
                        wr_addr <= payload_q;
                        wr_ok   <= 1'b1;
                    end
                    WR_DATA: if (wr_ok) wr_addr <= next_addr(wr_addr);
                    RD_ADDR: begin
                        rd_addr <= payload_q;
                        rd_ok   <= 1'b1;
                    end
                    RD_DATA: if (rd_ok) rd_addr <= next_addr(rd_addr);
                    default: ;
                endcase
            end
            if (state == ST_RD_WAIT) begin
                tx_data <= ram_q;
                tx_cnt  <= CNT_W'(ADDR_SIZE - 1);
            end else if (state == ST_TX && tx_cnt != '0) begin
                tx_cnt <= tx_cnt - 1'b1;
            end
        end
    end

    spi_sp_ram #(
        .ADDR_SIZE(ADDR_SIZE),
        .MEM_DEPTH(MEM_DEPTH)
    ) u_ram (
        .clk (clk),
        .we  (ram_we),
        .addr(ram_addr),
        .din (payload_q),
        .dout(ram_q)
    );

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Self-checking bench for spi_ram_ctrl: directed scenarios plus random
// command streams checked against a transaction-level memory model.
module tb_spi_ram_ctrl;

    localparam int unsigned A      = 8;
    localparam int unsigned DEPTH  = 256;
    localparam int          NO_INJ = 99;
    localparam int          NO_RST = 99;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [A+1:0] rx_data;
    logic         rx_valid;
    logic [A-1:0] tx_data;
    logic         tx_valid;
    logic         busy;
    logic         seq_err;
    logic         drop;

    int n_vec = 0;
    int n_err = 0;

    // Transaction-level reference state
    logic [A-1:0] m_mem [DEPTH];
    logic [A-1:0] m_wr, m_rd;
    bit           m_wr_ok, m_rd_ok;

    always #5 clk = ~clk;

    spi_ram_ctrl #(.ADDR_SIZE(A), .MEM_DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .busy    (busy),
        .seq_err (seq_err),
        .drop    (drop)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_wr    = '0;
        m_rd    = '0;
        m_wr_ok = 0;
        m_rd_ok = 0;
    endtask

    // Issue one command word and check every cycle of its transaction.
    // inj_c: cycle in which a stray rx_valid is injected; rst_c: cycle in which reset hits.
    task automatic run_cmd(input logic [1:0] cmd, input logic [A-1:0] pl,
                           input int inj_c, input int rst_c);
        bit           err, rd;
        int           last;
        logic [A-1:0] exp_q;
        err   = (cmd == 2'b01 && !m_wr_ok) || (cmd == 2'b11 && !m_rd_ok);
        rd    = (cmd == 2'b11) && !err;
        exp_q = '0;
        if (!err) begin
            case (cmd)
                2'b00: begin m_wr = pl; m_wr_ok = 1; end
                2'b01: begin m_mem[m_wr] = pl; m_wr = m_wr + 1'b1; end
                2'b10: begin m_rd = pl; m_rd_ok = 1; end
                default: begin exp_q = m_mem[m_rd]; m_rd = m_rd + 1'b1; end
            endcase
        end
        last     = rd ? A + 3 : 2;
        rx_data  = {cmd, pl};
        rx_valid = 1'b1;
        for (int c = 1; c <= last; c++) begin
            @(posedge clk); #1;
            rx_valid = 1'b0;
            if (c == rst_c) begin
                rst_n = 1'b0;
                #1;
                chk("async_rst_tx_valid", 32'(tx_valid), 0);
                chk("async_rst_busy", 32'(busy), 0);
                chk("async_rst_seq_err", 32'(seq_err), 0);
                chk("async_rst_drop", 32'(drop), 0);
                chk("async_rst_tx_data", 32'(tx_data), 0);
                model_reset();
                @(negedge clk);
                rst_n = 1'b1;
                @(posedge clk); #1;
                return;
            end
            chk($sformatf("busy c%0d cmd%0d", c, cmd), 32'(busy),
                32'(rd ? (c <= A + 2) : (c == 1)));
            chk($sformatf("seq_err c%0d cmd%0d", c, cmd), 32'(seq_err), 32'(err && c == 1));
            chk($sformatf("drop c%0d", c), 32'(drop), 32'(c == inj_c + 1));
            chk($sformatf("tx_valid c%0d cmd%0d", c, cmd), 32'(tx_valid),
                32'(rd && c >= 3 && c <= A + 2));
            if (rd && c >= 3 && c <= A + 2) begin
                chk($sformatf("tx_data c%0d rd%0h", c, m_rd - 1'b1), 32'(tx_data), 32'(exp_q));
            end
            if (c == inj_c) begin
                rx_data  = {2'b00, 8'h44};
                rx_valid = 1'b1;
            end
        end
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_tx_valid", 32'(tx_valid), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_seq_err", 32'(seq_err), 0);
        chk("reset_drop", 32'(drop), 0);
        chk("reset_tx_data", 32'(tx_data), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [1:0] rc;
        int         inj;
        do_reset();

        // Basic write then read back
        run_cmd(2'b00, 8'h10, NO_INJ, NO_RST);
        run_cmd(2'b01, 8'hA5, NO_INJ, NO_RST);
        run_cmd(2'b10, 8'h10, NO_INJ, NO_RST);
        run_cmd(2'b11, 8'h00, NO_INJ, NO_RST);

        // Fill the whole RAM so every later read has a known value
        run_cmd(2'b00, 8'h00, NO_INJ, NO_RST);
        for (int i = 0; i < int'(DEPTH); i++) begin
            run_cmd(2'b01, A'($urandom), NO_INJ, NO_RST);
        end

        // Address wrap on both write and read sides
        run_cmd(2'b00, 8'hFF, NO_INJ, NO_RST);
        run_cmd(2'b01, 8'h11, NO_INJ, NO_RST);
        run_cmd(2'b01, 8'h22, NO_INJ, NO_RST);
        run_cmd(2'b10, 8'hFF, NO_INJ, NO_RST);
        run_cmd(2'b11, 8'h00, NO_INJ, NO_RST);
        run_cmd(2'b11, 8'h00, NO_INJ, NO_RST);
        run_cmd(2'b10, 8'h00, NO_INJ, NO_RST);
        run_cmd(2'b11, 8'h00, NO_INJ, NO_RST);

        // Sequencing errors after reset; RAM[0] must keep 0x22
        do_reset();
        run_cmd(2'b11, 8'h00, NO_INJ, NO_RST);
        run_cmd(2'b01, 8'h33, NO_INJ, NO_RST);
        run_cmd(2'b10, 8'h00, NO_INJ, NO_RST);
        run_cmd(2'b11, 8'h00, NO_INJ, NO_RST);

        // Collision during TX: dropped, write address untouched
        run_cmd(2'b00, 8'h80, NO_INJ, NO_RST);
        run_cmd(2'b10, 8'h20, NO_INJ, NO_RST);
        run_cmd(2'b11, 8'h00, 5, NO_RST);
        run_cmd(2'b01, 8'h5C, NO_INJ, NO_RST);
        run_cmd(2'b10, 8'h80, NO_INJ, NO_RST);
        run_cmd(2'b11, 8'h00, NO_INJ, NO_RST);
        run_cmd(2'b10, 8'h44, NO_INJ, NO_RST);
        run_cmd(2'b11, 8'h00, NO_INJ, NO_RST);

        // Reset mid-TX, then data must survive
        run_cmd(2'b10, 8'h30, NO_INJ, NO_RST);
        run_cmd(2'b11, 8'h00, NO_INJ, 4);
        run_cmd(2'b11, 8'h00, NO_INJ, NO_RST);
        run_cmd(2'b10, 8'h30, NO_INJ, NO_RST);
        run_cmd(2'b11, 8'h00, NO_INJ, NO_RST);

        // Random command stream with occasional collisions
        for (int i = 0; i < 300; i++) begin
            rc  = 2'($urandom_range(0, 3));
            inj = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, A + 1)) : NO_INJ;
            if (rc != 2'b11 || !m_rd_ok) begin
                inj = NO_INJ;
            end
            run_cmd(rc, A'($urandom), inj, NO_RST);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
